// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between NUM_REQ
// requesters using rotate-priority (round-robin) arbitration. Operands are
// registered toward the ALU, and the result and flags are registered back to
// the winning requester. No arithmetic is performed here.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The source holds valid and payload stable until that edge. The
// sink may raise ready regardless of valid. req_* uses per-requester
// valid/ready. rsp_* uses a one-hot valid per requester and the matching
// rsp_ready bit; rsp_ready bits of non-granted requesters are ignored.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2,
  parameter int OP_WIDTH   = 3,
  localparam int GW        = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b,
  input  logic [NUM_REQ*OP_WIDTH-1:0]    req_op,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [DATA_WIDTH-1:0]          rsp_result,
  output logic                           rsp_zero,
  output logic                           rsp_carry,
  output logic                           rsp_overflow,
  output logic [DATA_WIDTH-1:0]          alu_a,
  output logic [DATA_WIDTH-1:0]          alu_b,
  output logic [OP_WIDTH-1:0]            alu_op,
  input  logic [DATA_WIDTH-1:0]          alu_result,
  input  logic                           alu_zero,
  input  logic                           alu_carry,
  input  logic                           alu_overflow,
  output logic                           busy,
  output logic [GW-1:0]                  grant_id,
  output logic [31:0]                    op_count,
  output logic [1:0]                     dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state, state_next;
  logic                  grant_found;
  logic [GW-1:0]         grant_idx;
  logic                  lo_found, hi_found;
  logic [GW-1:0]         lo_idx, hi_idx;
  logic [DATA_WIDTH-1:0] sel_a, sel_b;
  logic [OP_WIDTH-1:0]   sel_op;
  logic                  req_fire, rsp_fire;

  // grant_id doubles as last_grant: the search for the next winner starts one
  // past it. The descending scan leaves the lowest qualifying index in each
  // candidate: hi_* covers indices above last_grant (the wrap-free part of the
  // rotation), and lo_* is the fallback after wrapping to zero.
  always_comb begin
    lo_found = 1'b0;
    hi_found = 1'b0;
    lo_idx   = '0;
    hi_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = GW'(i);
        if (GW'(i) > grant_id) begin
          hi_found = 1'b1;
          hi_idx   = GW'(i);
        end
      end
    end
    grant_found = lo_found;
    grant_idx   = hi_found ? hi_idx : lo_idx;
  end

  // Select the winning requester's operands and op from the packed buses.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GW'(i) == grant_idx) begin
        sel_a  = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b  = req_b[i*DATA_WIDTH +: DATA_WIDTH];
        sel_op = req_op[i*OP_WIDTH +: OP_WIDTH];
      end
    end
  end

  // Next-state logic, handshake outputs and fire strobes.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    rsp_valid  = '0;
    req_fire   = 1'b0;
    rsp_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          req_ready  = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
          req_fire   = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        rsp_valid = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
        if (rsp_ready[grant_id]) begin
          rsp_fire   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus the operand, response, grant and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      grant_id     <= GW'(NUM_REQ - 1);
      op_count     <= '0;
    end else begin
      state <= state_next;
      if (req_fire) begin
        alu_a    <= sel_a;
        alu_b    <= sel_b;
        alu_op   <= sel_op;
        grant_id <= grant_idx;
      end
      if (state == EXEC) begin
        rsp_result   <= alu_result;
        rsp_zero     <= alu_zero;
        rsp_carry    <= alu_carry;
        rsp_overflow <= alu_overflow;
      end
      if (rsp_fire) begin
        op_count <= op_count + 32'd1;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single combinational ALU between NUM_REQ requesters, e.g. the execute stage and the address-generation/branch unit. It uses round-robin arbitration with a valid/ready request/response handshake. Operands are registered into the ALU, and the result and flags are registered back to the winning requester. It sits between the pipeline stages and the alu instance. It performs no arithmetic itself.

Parameters:
DATA_WIDTH, 32, operand/result width; must match the alu instance.
NUM_REQ, 2, number of requesters (2..8).
OP_WIDTH, 3, width of alu_op; passed through unmodified.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  NUM_REQ  per-requester request valid.
req_ready  out  NUM_REQ  per-requester request accept.
req_a  in  NUM_REQ*DATA_WIDTH  operand a; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
req_b  in  NUM_REQ*DATA_WIDTH  operand b, same packing.
req_op  in  NUM_REQ*OP_WIDTH  ALU op code, same packing.
rsp_valid  out  NUM_REQ  response valid, one-hot to the granted requester.
rsp_ready  in  NUM_REQ  per-requester response accept.
rsp_result  out  DATA_WIDTH  registered ALU result (shared bus).
rsp_zero, rsp_carry, rsp_overflow  out  1 each  registered ALU flags.
alu_a, alu_b  out  DATA_WIDTH  registered operands to the alu.
alu_op  out  OP_WIDTH  registered op to the alu.
alu_result  in  DATA_WIDTH  from the alu.
alu_zero, alu_carry, alu_overflow  in  1 each  from the alu.
busy  out  1  high whenever state is not IDLE.
grant_id  out  $clog2(NUM_REQ)  index of the current/last granted requester.
op_count  out  32  completed-transaction counter.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - req_ready=0, rsp_valid=0, busy=0.
  - alu_a, alu_b, alu_op, rsp_result and all rsp flags = 0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority; grant_id=NUM_REQ-1.
  - op_count=0.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Grant is chosen combinationally: the first i with req_valid[i]=1, searching from last_grant+1 upward modulo NUM_REQ.
  - req_ready[g]=1 for the granted index only; all other req_ready bits are 0. With no valid request, req_ready is all 0.
  - On valid&ready, the next edge latches req_a/b/op[g] into alu_a/b/op, sets grant_id=g and last_grant=g, and moves to EXEC.
- EXEC: lasts one cycle, during which the ALU settles. The next edge captures alu_result and the three flags into the rsp_* registers and moves to RESP.
- RESP:
  - rsp_valid[grant_id]=1 and held, with rsp_* stable, until rsp_ready[grant_id]=1.
  - The accepting edge increments op_count (wraps at 2^32) and returns to IDLE.
  - rsp_ready on non-granted bits is ignored.
- Latency and throughput:
  - req accept to rsp_valid is 2 cycles.
  - Minimum 3 cycles per transaction with no overlap; a new grant is possible in the cycle after rsp acceptance.
- req_ready is 0 in EXEC and RESP. Requesters hold their valid; nothing is dropped.
- A requester may drop req_valid before being granted; no transfer occurs.
- alu_a/b/op hold their last values after a transaction and do not return to 0.
- Simultaneous requests resolve by round-robin from last_grant+1. A continuously requesting set therefore alternates grants; a single active requester is granted repeatedly.
- rst asserted in EXEC or RESP discards the in-flight operation: no rsp_valid is produced and op_count is not incremented.
- Implementation size: the rotate-priority arbiter is generic in NUM_REQ (no hardcoded 2-way logic).

Test Plan:
- Single request: req0 a=0x00000005, b=0x00000003, op=ADD, valid for 1 cycle, rsp_ready=1 -> req_ready[0] high in cycle 0; rsp_valid=2'b01 at cycle 2 with rsp_result=0x00000008, zero=0; op_count=1.
- Both requesters continuously valid with distinct operands (req0 1+1, req1 0xFFFFFFFF+1) -> grants alternate 0,1,0,1. req1 response gives rsp_result=0x00000000, zero=1, carry=1.
- Backpressure: rsp_ready[0]=0 for 5 cycles in RESP -> rsp_valid[0] and rsp_result remain constant, req_ready=0 for both, and req1 stays pending. The grant goes to req1 only after acceptance.
- Overflow passthrough: a=0x7FFFFFFF, b=0x00000001, ADD -> rsp_result=0x80000000, overflow=1, carry=0.
- Reset mid-operation: assert rst during EXEC -> rsp_valid=0, busy=0, op_count unchanged (0). The next request after deassertion is granted to requester 0.
- Random: 1000 random a/b from both requesters with random rsp_ready stalls -> every response matches a+b of its own request, with no loss or duplication; op_count=1000.
